// File: rtl/match_logger.sv
// match_logger: timestamps every cycle the upstream sequence detector asserts
// its match output and queues the timestamps in a show-ahead FIFO for a host.
// It also keeps a saturating total match count and a sticky overflow flag.
//
// Parameters:
//   DEPTH - FIFO entries (power of two, >= 2)
//   TS_W  - width of the free-running timestamp counter
//   CNT_W - width of the saturating match counter
//
// Ports:
//   clk       - clock; all state updates on the rising edge
//   rst_n     - synchronous active-low reset
//   match     - detector output, one event per high edge
//   rd_en     - pop request for the head entry (ignored when empty)
//   rd_data   - head-entry timestamp, 0 when empty
//   rd_valid  - FIFO not empty
//   full      - FIFO holds DEPTH entries
//   fill      - number of entries held
//   match_cnt - total events seen, saturating
//   overflow  - sticky; an event was dropped because the FIFO was full
module match_logger #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TS_W  = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       match,
  input  logic                       rd_en,
  output logic [TS_W-1:0]            rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     fill,
  output logic [CNT_W-1:0]           match_cnt,
  output logic                       overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [TS_W-1:0]  mem [DEPTH];
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    wptr;
  logic [AW:0]      fill_q;
  logic [TS_W-1:0]  ts;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;

  logic pop;
  logic wr;

  always_comb begin
    pop = rd_en && (fill_q != '0);
    // A full FIFO still accepts an event when the head is popped on the same edge.
    wr  = match && ((fill_q != FULL_LVL) || pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts     <= '0;
      rptr   <= '0;
      wptr   <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      ts <= ts + TS_W'(1);
      if (pop) rptr <= rptr + AW'(1);
      if (wr)  wptr <= wptr + AW'(1);
      case ({wr, pop})
        2'b10:   fill_q <= fill_q + (AW+1)'(1);
        2'b01:   fill_q <= fill_q - (AW+1)'(1);
        default: fill_q <= fill_q;
      endcase
      if (match && !wr) ovf_q <= 1'b1;
      if (match && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Storage is not reset; rd_data is masked while empty instead.
  always_ff @(posedge clk) begin
    if (rst_n && wr) mem[wptr] <= ts;
  end

  always_comb begin
    rd_valid  = (fill_q != '0);
    full      = (fill_q == FULL_LVL);
    fill      = fill_q;
    match_cnt = cnt_q;
    overflow  = ovf_q;
    rd_data   = rd_valid ? mem[rptr] : '0;
  end

endmodule

// File: tb/tb_match_logger.sv
module tb_match_logger;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TS_W  = 16;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             match;
  logic             rd_en;
  logic [TS_W-1:0]  rd_data;
  logic             rd_valid;
  logic             full;
  logic [3:0]       fill;
  logic [CNT_W-1:0] match_cnt;
  logic             overflow;

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Reference model: timestamp counter, queue of timestamps, count, flag.
  int unsigned     ts_m;
  logic [TS_W-1:0] q[$];
  int unsigned     cnt_m;
  bit              ovf_m;

  match_logger #(.DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .match(match), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .fill(fill),
    .match_cnt(match_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive inputs between edges, apply one edge, update the model, sample 1ns later.
  task automatic step(input logic rn, input logic m, input logic r);
    bit do_pop, do_wr;
    @(negedge clk);
    rst_n = rn; match = m; rd_en = r;
    @(posedge clk);
    if (!rn) begin
      ts_m = 0; q.delete(); cnt_m = 0; ovf_m = 0;
    end else begin
      do_pop = r && (q.size() > 0);
      do_wr  = m && (q.size() < DEPTH || do_pop);
      if (do_pop) void'(q.pop_front());
      if (do_wr)  q.push_back(TS_W'(ts_m));
      if (m && !do_wr) ovf_m = 1;
      if (m && cnt_m < (1 << CNT_W) - 1) cnt_m++;
      ts_m = (ts_m + 1) % (1 << TS_W);
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(q.size() != 0));
    chk({tag, ".rd_data"},  32'(rd_data),  (q.size() != 0) ? 32'(q[0]) : 32'd0);
    chk({tag, ".fill"},     32'(fill),     32'(q.size()));
    chk({tag, ".full"},     32'(full),     32'(q.size() == DEPTH));
    chk({tag, ".cnt"},      32'(match_cnt), 32'(cnt_m));
    chk({tag, ".ovf"},      32'(overflow), 32'(ovf_m));
  endtask

  int unsigned digits[20] = '{7,5,1,0,2,2,1,0,2,2,1,0,3,9,2,1,0,2,2,8};
  int unsigned hist[4];
  int unsigned pulses;
  logic [TS_W-1:0] e[4];
  logic y;

  initial begin
    rst_n = 1'b0; match = 1'b0; rd_en = 1'b0;

    // Reset, then a match on the very first active edge.
    step(0, 1, 1);
    chk("reset.rd_valid", 32'(rd_valid), 32'd0);
    chk("reset.rd_data",  32'(rd_data),  32'd0);
    chk("reset.fill",     32'(fill),     32'd0);
    check_all("reset");
    step(1, 1, 0);
    chk("first.rd_data", 32'(rd_data),   32'd0);
    chk("first.fill",    32'(fill),      32'd1);
    chk("first.cnt",     32'(match_cnt), 32'd1);
    check_all("first");

    // Detector stream: y is high when the last four digits read 2,2,1,0.
    step(0, 0, 0);
    hist = '{default: 99};
    pulses = 0;
    for (int unsigned k = 0; k < 40; k++) begin
      hist[0] = hist[1]; hist[1] = hist[2]; hist[2] = hist[3]; hist[3] = digits[k % 20];
      y = (hist[0] == 2 && hist[1] == 2 && hist[2] == 1 && hist[3] == 0);
      if (y) pulses++;
      step(1, y, 0);
      check_all("stream");
    end
    chk("stream.cnt_pulses", 32'(match_cnt), 32'(pulses));
    for (int unsigned k = 0; k < 4; k++) begin
      e[k] = rd_data;
      step(1, 0, 1);
      check_all("stream.pop");
    end
    chk("stream.diff01", 32'(e[1]), 32'(e[0]) + 32'd4);
    chk("stream.diff23", 32'(e[3]), 32'(e[2]) + 32'd4);

    // Nine events into an 8-deep FIFO, then drain.
    step(0, 0, 0);
    for (int unsigned k = 0; k < 9; k++) begin
      step(1, 1, 0);
      check_all("fill9");
      if (k == 7) begin
        chk("fill9.full8", 32'(full), 32'd1);
        chk("fill9.ovf8",  32'(overflow), 32'd0);
      end
    end
    chk("fill9.ovf",  32'(overflow),  32'd1);
    chk("fill9.fill", 32'(fill),      32'd8);
    chk("fill9.cnt",  32'(match_cnt), 32'd9);
    for (int unsigned k = 0; k < 8; k++) begin
      chk("drain.order", 32'(rd_data), 32'(k));
      step(1, 0, 1);
      check_all("drain");
    end

    // Full FIFO with simultaneous pop and write.
    step(0, 0, 0);
    for (int unsigned k = 0; k < 8; k++) step(1, 1, 0);
    step(1, 1, 1);
    chk("fullrw.fill", 32'(fill),     32'd8);
    chk("fullrw.ovf",  32'(overflow), 32'd0);
    chk("fullrw.head", 32'(rd_data),  32'd1);
    check_all("fullrw");

    // fill==1 with simultaneous pop and write shows the new entry.
    step(0, 0, 0);
    step(1, 1, 0);
    step(1, 1, 1);
    chk("one_rw.head",  32'(rd_data),  32'd1);
    chk("one_rw.valid", 32'(rd_valid), 32'd1);
    check_all("one_rw");

    // Pops while empty are ignored.
    step(0, 0, 0);
    for (int unsigned k = 0; k < 5; k++) begin
      step(1, 0, 1);
      chk("empty_pop.fill",  32'(fill),     32'd0);
      chk("empty_pop.valid", 32'(rd_valid), 32'd0);
    end
    step(1, 1, 0);
    chk("empty_pop.ts", 32'(rd_data), 32'd5);
    check_all("empty_pop");

    // Randomized traffic against the model.
    step(0, 0, 0);
    for (int unsigned k = 0; k < 400; k++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) != 0), ($urandom_range(0, 1) != 0));
      check_all("rand");
    end

    // 300 consecutive matches saturate the counter.
    step(0, 0, 0);
    for (int unsigned k = 0; k < 300; k++) step(1, 1, 1);
    chk("sat.cnt", 32'(match_cnt), 32'd255);
    check_all("sat");

    // Timestamp wrap: events logged at ts=FFFF and at the following 0.
    step(0, 0, 0);
    while (ts_m != 32'hFFFF) step(1, 0, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    chk("wrap.head", 32'(rd_data), 32'hFFFF);
    check_all("wrap");
    step(1, 0, 1);
    chk("wrap.next", 32'(rd_data), 32'd0);
    check_all("wrap.pop");

    // Mid-run reset clears everything, ignoring match/rd_en on that edge.
    step(1, 1, 0);
    step(0, 1, 1);
    chk("midrst.valid", 32'(rd_valid),  32'd0);
    chk("midrst.data",  32'(rd_data),   32'd0);
    chk("midrst.fill",  32'(fill),      32'd0);
    chk("midrst.full",  32'(full),      32'd0);
    chk("midrst.cnt",   32'(match_cnt), 32'd0);
    chk("midrst.ovf",   32'(overflow),  32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/match_logger.md
# match_logger

Downstream stage of the sequence detector. It consumes the detector's one-bit match output. Every cycle in which that output is high is timestamped with a free-running cycle counter and the timestamp is queued in a small show-ahead FIFO that a host reads with a simple pop handshake. The block also keeps a saturating total match count and a sticky overflow flag, so the detector can be checked over long runs without a bench sampling `y` every cycle.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, minimum 2.
- `TS_W`, 16: timestamp counter width.
- `CNT_W`, 8: match counter width.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `match`  in  1: detector output `y`; sampled every rising edge.
- `rd_en`  in  1: pop request for the head entry.
- `rd_data`  out  TS_W: head-entry timestamp; valid while `rd_valid`=1.
- `rd_valid`  out  1: FIFO not empty.
- `full`  out  1: FIFO holds DEPTH entries.
- `fill`  out  log2(DEPTH)+1: number of entries held.
- `match_cnt`  out  CNT_W: total matches seen, saturating.
- `overflow`  out  1: sticky; a match was dropped.

## Operation
- Timestamp counter `ts`:
  - Increments by 1 at every edge where `rst_n`=1.
  - Wraps from 2^TS_W-1 to 0 with no flag.
- Event definition:
  - Each edge with `match`=1 is one event; there is no edge detection.
  - A two-cycle-high `match` therefore logs two events.
  - The stored timestamp is the `ts` value before that edge's increment.
- Write acceptance:
  - An event is written when `fill`<DEPTH.
  - An event is also written when `fill`==DEPTH and a pop happens on the same edge.
  - Otherwise the event is dropped and `overflow` is set.
- Pop:
  - A pop happens when `rd_en`=1 and `rd_valid`=1.
  - `rd_en` while the FIFO is empty is ignored. `fill` stays at 0 and no underflow state changes.
- Simultaneous pop and write on one edge:
  - `fill` is unchanged.
  - Both pointers advance.
- FIFO with `fill`==1 and a simultaneous pop and write:
  - After the edge, `rd_data` shows the new entry.
  - `rd_valid` stays 1.
- `match_cnt`:
  - Increments on every event, accepted or dropped.
  - Holds at 2^CNT_W-1 and does not wrap.
- `overflow` clears only on reset.
- Storage:
  - Circular buffer with read and write pointers of log2(DEPTH) bits each, wrapping modulo DEPTH.
  - `fill` is held as an explicit counter.

## Timing
- Every output is registered or derived combinationally from registers; there is no combinational path from `match` or `rd_en` to any output.
- Reset:
  - At an edge with `rst_n`=0 the following clear to 0: `ts`, both pointers, `fill`, `match_cnt`, `overflow`.
  - Consequently `rd_valid`=0, `full`=0 and `rd_data`=0.
  - Reset applied mid-operation discards all queued entries on that edge.
  - Any `match` or `rd_en` on a reset edge is ignored.
- Write-to-read latency is 1 cycle: an event accepted at edge N makes `rd_valid`=1 and `rd_data`=timestamp after edge N.
- Pop latency is 0: `rd_data` shows the next entry after the popping edge.
- `full` and `fill` update on the same edge as the write or pop that changes them.
- `overflow` rises on the edge of the first dropped event.
- `match_cnt` is updated on the event's own edge.

## Test plan
- Reset, then `rst_n`=1 with `match`=1 on the first edge only -> `rd_valid`=1, `rd_data`=0, `fill`=1, `match_cnt`=1.
- Feed the detector the digit stream 7,5,1,0,2,2,1,0,2,2,1,0,3,9,2,1,0,2,2,8 repeating, driving `match` from its `y`, with `rd_en`=0 -> events every 4 cycles within a run. Check:
  - The timestamps in the FIFO differ by 4.
  - `match_cnt` equals the number of `y` pulses.
- Nine events with `rd_en`=0 (DEPTH=8):
  - `full`=1 after the 8th event.
  - The 9th event sets `overflow`=1 and leaves `fill`=8.
  - `match_cnt`=9.
  - Popping 8 times returns the first 8 timestamps in order.
- FIFO full, `match`=1 and `rd_en`=1 on the same edge:
  - The oldest entry is popped and the new one written.
  - `fill` stays 8 and `overflow` stays 0.
- `rd_en`=1 held high for 5 cycles while empty -> `fill`=0, `rd_valid`=0 and the pointers are unchanged. A subsequent event at `ts`=T reads back as T.
- Long run:
  - `match` held high for 300 cycles gives `match_cnt`=255 (saturated).
  - `ts` wraps after 65536 cycles, and the event logged at the wrap reads 0xFFFF.
  - `rst_n`=0 for one edge mid-run clears all outputs to 0.
